// File: rtl/arith_iter_unit.sv
// arith_iter_unit: add/sub/pass in one cycle, shift-add multiply
// one bit per cycle, valid/ready on both sides, one op in flight.
module arith_iter_unit #(
  parameter  int WIDTH = 4,
  localparam int RES_W = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic             out_busy
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [RES_W-1:0] acc_q, acc_d;
  logic [RES_W-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RES_W-1:0] res_q, res_d;

  logic [RES_W-1:0] a_ext, b_ext;
  logic [RES_W-1:0] fast_res;
  logic [RES_W-1:0] acc_step;

  assign a_ext = {{WIDTH{1'b0}}, in_a};
  assign b_ext = {{WIDTH{1'b0}}, in_b};

  // Single-cycle results; subtract wraps across the full result width
  always_comb begin
    fast_res = a_ext + b_ext;
    case (in_op)
      OP_ADD:  fast_res = a_ext + b_ext;
      OP_SUB:  fast_res = a_ext - b_ext;
      default: fast_res = {in_b, in_a};
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state: accept in IDLE, step in MUL, hold in DONE until taken
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_op == OP_MUL) begin
            acc_d    = '0;
            mcand_d  = a_ext;
            mplier_d = in_b;
            cnt_d    = CW'(WIDTH);
            state_d  = S_MUL;
          end else begin
            res_d   = fast_res;
            state_d = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          res_d   = acc_step;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_busy  = (state_q == S_MUL);
  assign out_res   = res_q;

endmodule

// File: tb/tb_arith_iter_unit.sv
// tb_arith_iter_unit: directed checks on a 4-bit instance and a
// randomized scoreboard sweep on an 8-bit instance.
module tb_arith_iter_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic       in_valid4 = 0, in_ready4, out_valid4, out_ready4 = 0;
  logic       out_busy4;
  logic [3:0] in_a4 = 0, in_b4 = 0;
  logic [1:0] in_op4 = 0;
  logic [7:0] out_res4;

  logic        in_valid8 = 0, in_ready8, out_valid8, out_ready8 = 0;
  logic        out_busy8;
  logic [7:0]  in_a8 = 0, in_b8 = 0;
  logic [1:0]  in_op8 = 0;
  logic [15:0] out_res8;

  arith_iter_unit #(.WIDTH(4)) d4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_op(in_op4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_res(out_res4), .out_busy(out_busy4)
  );

  arith_iter_unit #(.WIDTH(8)) r8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_res(out_res8), .out_busy(out_busy8)
  );

  longint q4[$];
  longint q8[$];
  int xfer4 = 0, xfer8 = 0, acc8 = 0;

  function automatic longint model(int w, longint a, longint b, int op);
    longint m;
    m = (longint'(1) << (2 * w)) - 1;
    case (op)
      0:       return a + b;
      1:       return (a - b) & m;
      2:       return a * b;
      default: return (b << w) | a;
    endcase
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // input-side scoreboard feeders
  always @(negedge clk) begin
    if (rst_n && in_valid4 && in_ready4)
      q4.push_back(model(4, in_a4, in_b4, in_op4));
    if (rst_n && in_valid8 && in_ready8) begin
      q8.push_back(model(8, in_a8, in_b8, in_op8));
      acc8++;
    end
  end

  // output-side monitors
  always @(negedge clk) begin
    if (rst_n && out_valid4) begin
      chk("d4 excl", {in_ready4, out_busy4}, 0);
      if (q4.size() == 0) begin
        tests++; fails++;
        $display("FAIL d4 spurious: got %0h expected none", out_res4);
      end else begin
        chk("d4 res", out_res4, q4[0]);
        if (out_ready4) begin
          void'(q4.pop_front());
          xfer4++;
        end
      end
    end
    if (rst_n && out_valid8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL r8 spurious: got %0h expected none", out_res8);
      end else begin
        chk("r8 res", out_res8, q8[0]);
        if (out_ready8) begin
          void'(q8.pop_front());
          xfer8++;
        end
      end
    end
    if (rst_n && (out_valid8 && (in_ready8 || out_busy8))) begin
      tests++; fails++;
      $display("FAIL r8 excl: got valid with ready/busy");
    end
  end

  always begin
    @(posedge clk); #1;
    out_ready8 = ($urandom % 4) != 0;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic go4(input int a, input int b, input int op, input int exp);
    int lat, bsy;
    in_a4 = 4'(a); in_b4 = 4'(b); in_op4 = 2'(op);
    in_valid4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0;
    lat = 0; bsy = 0;
    while (!out_valid4 && lat < 40) begin
      if (out_busy4) bsy++;
      @(posedge clk); #1;
      lat++;
    end
    chk("d4 latency", lat, op == 2 ? 4 : 0);
    chk("d4 busy cycles", bsy, op == 2 ? 4 : 0);
    chk("d4 value", out_res4, exp);
    chk("d4 in_ready in done", in_ready4, 0);
  endtask

  task automatic take4();
    @(posedge clk); #1;
    chk("d4 valid after xfer", out_valid4, 0);
    chk("d4 in_ready after xfer", in_ready4, 1);
  endtask

  initial begin
    int guard, x0;
    bit ok;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", {in_ready4, in_ready8}, 2'b11);
    chk("rst out_valid", {out_valid4, out_valid8}, 0);
    chk("rst busy", {out_busy4, out_busy8}, 0);
    chk("rst res", {out_res4, out_res8}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    out_ready4 = 1;
    go4(9, 8, 0, 'h11);  take4();
    go4(3, 5, 1, 'hFE);  take4();
    go4(5, 3, 1, 'h02);  take4();
    go4(15, 15, 2, 'hE1); take4();
    go4(0, 0, 2, 'h00);  take4();
    go4(6, 9, 3, 'h96);  take4();
    go4(15, 1, 0, 'h10); take4();
    go4(0, 15, 1, 'hF1); take4();

    out_ready4 = 0;
    go4(7, 6, 2, 'h2A);
    for (int i = 0; i < 10; i++) begin
      in_a4 = 4'($urandom); in_b4 = 4'($urandom);
      in_op4 = 2'($urandom); in_valid4 = i[0];
      @(posedge clk); #1;
      chk("stall valid", out_valid4, 1);
      chk("stall res", out_res4, 'h2A);
    end
    in_valid4 = 0;
    x0 = xfer4;
    out_ready4 = 1;
    @(posedge clk); #1;
    chk("stall xfer valid", out_valid4, 0);
    chk("stall xfer count", xfer4 - x0, 1);
    chk("stall queue empty", q4.size(), 0);
    @(posedge clk); #1;
    chk("stall in_ready", in_ready4, 1);

    in_a4 = 13; in_b4 = 11; in_op4 = 2; in_valid4 = 1;
    @(posedge clk); #1;
    in_valid4 = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 0;
    q4.delete();
    #1;
    chk("mid rst in_ready", in_ready4, 1);
    chk("mid rst valid", out_valid4, 0);
    chk("mid rst busy", out_busy4, 0);
    chk("mid rst res", out_res4, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post rst no valid", out_valid4, 0);
    end
    go4(1, 1, 0, 'h02); take4();
    chk("d4 drained", q4.size(), 0);

    for (int n = 0; n < 10000; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      in_a8 = 8'($urandom); in_b8 = 8'($urandom);
      in_op8 = 2'($urandom); in_valid8 = 1;
      guard = 0;
      do begin
        @(negedge clk);
        ok = in_ready8;
        @(posedge clk); #1;
        guard++;
      end while (!ok && guard < 200);
      in_valid8 = 0;
      if (!ok) begin
        tests++; fails++;
        $display("FAIL r8 accept: got stuck expected in_ready");
        break;
      end
    end
    guard = 0;
    while ((q8.size() != 0 || xfer8 != acc8) && guard < 1000) begin
      @(posedge clk); guard++;
    end
    chk("r8 accepted", acc8, 10000);
    chk("r8 transferred", xfer8, 10000);
    chk("r8 queue empty", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
